// File: rtl/counter_ud_sequencer.sv
// Command sequencer for an up/down counter: runs to a target, or bounces
// 0<->target N times, stopping exactly on goal and flagging a stalled counter.
module counter_ud_sequencer #(
    parameter int WIDTH   = 8,
    parameter int REP_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic [REP_W-1:0] cmd_reps,
    input  logic             abort,
    input  logic [WIDTH-1:0] ctr_val,
    output logic             ctr_en,
    output logic             ctr_ud,
    output logic             ctr_clr,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [REP_W-1:0] pass_cnt
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;
    typedef enum logic [1:0] {M_UP, M_DOWN, M_BOUNCE, M_RSVD} mode_t;

    state_t           state;
    mode_t            mode;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] goal;
    logic [WIDTH-1:0] prev_val;
    logic [REP_W-1:0] reps;
    logic [WD_W-1:0]  wd_cnt;

    logic             at_goal;
    logic             stall;
    logic             wd_hit;
    logic [REP_W-1:0] pass_nxt;

    assign at_goal  = (ctr_val == goal);
    // Enable is combinational so the counter never steps past the goal
    assign ctr_en   = (state == RUN) && !at_goal;
    assign stall    = ctr_en && (ctr_val == prev_val);
    assign wd_hit   = stall && (wd_cnt == WD_W'(TIMEOUT - 1));
    assign pass_nxt = pass_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mode      <= M_UP;
            target    <= '0;
            goal      <= '0;
            prev_val  <= '0;
            reps      <= '0;
            wd_cnt    <= '0;
            cmd_ready <= 1'b1;
            ctr_ud    <= 1'b1;
            ctr_clr   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            pass_cnt  <= '0;
        end else begin
            ctr_clr  <= 1'b0;
            prev_val <= ctr_val;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        mode      <= mode_t'(cmd_mode);
                        target    <= cmd_target;
                        goal      <= cmd_target;
                        reps      <= (cmd_reps == '0) ? REP_W'(1) : cmd_reps;
                        err       <= 1'b0;
                        pass_cnt  <= '0;
                        wd_cnt    <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        unique case (mode_t'(cmd_mode))
                            M_UP: begin
                                state  <= RUN;
                                ctr_ud <= 1'b1;
                            end
                            M_DOWN: begin
                                state  <= RUN;
                                ctr_ud <= 1'b0;
                            end
                            M_BOUNCE: begin
                                state   <= CLR;
                                ctr_ud  <= 1'b1;
                                ctr_clr <= 1'b1;
                            end
                            M_RSVD: begin
                                state <= DONE;
                                err   <= 1'b1;
                                done  <= 1'b1;
                            end
                        endcase
                    end
                end
                CLR: begin
                    if (abort) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    wd_cnt <= stall ? wd_cnt + 1'b1 : '0;
                    if (abort) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (wd_hit) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else if (at_goal) begin
                        if (mode != M_BOUNCE) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (ctr_ud && target != '0) begin
                            ctr_ud <= 1'b0;
                            goal   <= '0;
                        end else begin
                            // Back at zero (or target==0): one pass done
                            pass_cnt <= pass_nxt;
                            if (pass_nxt == reps) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                ctr_ud <= 1'b1;
                                goal   <= target;
                            end
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_ud_sequencer.sv
// Randomized scoreboard bench for counter_ud_sequencer with a counter model
// that can be loaded or frozen.
module tb_counter_ud_sequencer;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_mode = '0;
    logic [7:0] cmd_target = '0;
    logic [3:0] cmd_reps = '0;
    logic       abort = 1'b0;
    logic [7:0] ctr_val;
    logic       ctr_en, ctr_ud, ctr_clr, busy, done, err;
    logic [3:0] pass_cnt;

    counter_ud_sequencer #(.WIDTH(8), .REP_W(4), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_target(cmd_target), .cmd_reps(cmd_reps), .abort(abort),
        .ctr_val(ctr_val), .ctr_en(ctr_en), .ctr_ud(ctr_ud),
        .ctr_clr(ctr_clr), .busy(busy), .done(done), .err(err),
        .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    // Counter under control: load port for test setup, freeze for stall tests
    logic [7:0] cnt = '0;
    logic       ld = 1'b0;
    logic [7:0] ld_val = '0;
    logic       frozen = 1'b0;
    assign ctr_val = cnt;

    always @(posedge clk) begin
        if (ld) cnt <= ld_val;
        else if (!frozen) begin
            if (ctr_clr) cnt <= '0;
            else if (ctr_en) cnt <= ctr_ud ? cnt + 8'd1 : cnt - 8'd1;
        end
    end

    typedef struct {
        int lat;
        int ens;
        int val;
        int err;
        int pc;
        int clr;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   nvec = 0;
    int   nbad = 0;
    int   cyc = 0;
    int   acc = 0;
    int   ens = 0;
    int   clrs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        nvec++;
        if (act !== expv) begin
            nbad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: totals per command from the counting rules
    function automatic exp_t model(input int mode, input int tgt, input int reps,
                                   input int start, input bit frz, input int abj);
        exp_t m;
        int n, r;
        m.lat = 0; m.ens = 0; m.val = start; m.err = 0; m.pc = 0; m.clr = 0;
        if (mode == 3) begin
            m.lat = 1;
            m.err = 1;
        end else if (mode == 2) begin
            r = (reps == 0) ? 1 : reps;
            m.lat = ((tgt == 0) ? r : r * (2 * tgt + 2)) + 2;
            m.ens = 2 * tgt * r;
            m.val = 0;
            m.pc  = r;
            m.clr = 1;
        end else if (frz) begin
            m.lat = TO + 1;
            m.ens = TO;
            m.err = 1;
        end else begin
            n = (mode == 0) ? ((tgt - start) & 255) : ((start - tgt) & 255);
            if (abj >= 0 && abj < n) begin
                m.ens = abj + 1;
                m.val = ((mode == 0) ? start + abj + 1 : start - abj - 1) & 255;
                m.lat = abj + 2;
            end else begin
                m.ens = n;
                m.val = tgt;
                m.lat = n + 2;
            end
        end
        return m;
    endfunction

    // Monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        if (reset) begin
            if (ctr_en) ens++;
            if (ctr_clr) clrs++;
            if (done) begin
                if (q.size() == 0) begin
                    nvec++;
                    nbad++;
                    $display("FAIL spurious_done: got done=1, expected no pending command");
                end else begin
                    e = q.pop_front();
                    chk("latency", cyc - acc, e.lat);
                    chk("enables", ens, e.ens);
                    chk("final_val", int'(ctr_val), e.val);
                    chk("err", int'(err), e.err);
                    chk("pass_cnt", int'(pass_cnt), e.pc);
                    chk("clr_pulses", clrs, e.clr);
                    chk("busy_in_done", int'(busy), 1);
                end
            end
            if (cmd_valid && cmd_ready) begin
                acc  = cyc;
                ens  = 0;
                clrs = 0;
            end
        end
    end

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            nvec++;
            nbad++;
            $display("FAIL ready_timeout: got cmd_ready=0, expected 1 within 3000 cycles");
        end
    endtask

    task automatic run_cmd(input int mode, input int tgt, input int reps,
                           input int start, input bit frz, input int abj);
        wait_ready();
        frozen = 1'b0;
        if (mode < 2) begin
            ld     = 1'b1;
            ld_val = 8'(start);
            @(negedge clk);
            ld = 1'b0;
        end
        q.push_back(model(mode, tgt, reps, int'(cnt), frz, abj));
        frozen     = frz;
        cmd_valid  = 1'b1;
        cmd_mode   = 2'(mode);
        cmd_target = 8'(tgt);
        cmd_reps   = 4'(reps);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (abj >= 0) begin
            repeat (abj) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
    endtask

    initial begin
        int mode, tgt, reps, start, abj, n;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_ctr_en", int'(ctr_en), 0);
        chk("rst_ctr_ud", int'(ctr_ud), 1);
        chk("rst_ctr_clr", int'(ctr_clr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_pass_cnt", int'(pass_cnt), 0);
        reset = 1'b1;

        // Reset asserted mid-RUN
        run_cmd(1, 0, 0, 200, 1'b0, -1);
        repeat (20) @(negedge clk);
        chk("midrun_ctr_en", int'(ctr_en), 1);
        chk("midrun_ctr_ud", int'(ctr_ud), 0);
        #2 reset = 1'b0;
        #1;
        chk("async_ctr_en", int'(ctr_en), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_done", int'(done), 0);
        chk("async_ctr_ud", int'(ctr_ud), 1);
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", int'(cmd_ready), 1);

        run_cmd(0, 10, 0, 0, 1'b0, -1);
        run_cmd(0, 3, 0, 250, 1'b0, -1);
        run_cmd(1, 5, 0, 5, 1'b0, -1);
        run_cmd(2, 4, 2, 0, 1'b0, -1);
        run_cmd(2, 7, 0, 0, 1'b0, -1);
        run_cmd(2, 0, 3, 0, 1'b0, -1);
        run_cmd(0, 8, 0, 2, 1'b1, -1);
        wait_ready();
        chk("err_sticky_idle", int'(err), 1);
        run_cmd(1, 3, 0, 10, 1'b0, -1);
        run_cmd(0, 20, 0, 15, 1'b0, 5);
        run_cmd(0, 50, 0, 0, 1'b0, 7);
        run_cmd(3, 9, 0, 0, 1'b0, -1);

        for (int i = 0; i < 40; i++) begin
            mode  = int'($urandom_range(0, 3));
            reps  = int'($urandom_range(0, 15));
            start = int'($urandom_range(0, 255));
            tgt   = (mode == 2) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 255));
            abj   = -1;
            if (mode < 2 && $urandom_range(0, 3) == 0) begin
                n   = (mode == 0) ? ((tgt - start) & 255) : ((start - tgt) & 255);
                abj = int'($urandom_range(0, n + 2));
            end
            run_cmd(mode, tgt, reps, start, 1'b0, abj);
        end

        for (int i = 0; i < 3000 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            nvec++;
            nbad++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
        end
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
